mod: RTL and testbench

MOD -- requirements
Module: mod

---
 rtl/mod.sv | 94 +++++++++
 tb/tb_mod.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mod.sv
// Modulo-MODULUS up/down counter with synchronous load and a terminal-count wrap pulse.
// Optional: define MOD_WRAPS_EN to add the saturating 8-bit wrap counter output 'wraps'.
module mod #(
  parameter int MODULUS = 42,
  localparam int W = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
`ifdef MOD_WRAPS_EN
  output logic [7:0]   wraps,
`endif
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] MAX_VAL  = W'(MODULUS - 1);
  localparam logic [W:0]   MOD_WIDE = (W + 1)'(MODULUS);

  logic [W-1:0] count_reg, count_next;
  logic         tc_reg, tc_next;
  logic [W-1:0] load_clamped;

  // Compare one bit wider so MODULUS == 2^W cannot alias to zero.
  always_comb begin
    load_clamped = load_val;
    if ({1'b0, load_val} >= MOD_WIDE) begin
      load_clamped = MAX_VAL;
    end
  end

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      if (up) begin
        if (count_reg == MAX_VAL) begin
          count_next = '0;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg + W'(1);
        end
      end else begin
        if (count_reg == '0) begin
          count_next = MAX_VAL;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;

`ifdef MOD_WRAPS_EN
  logic [7:0] wraps_reg, wraps_next;

  // Bumped on the same edge that raises tc, so wraps always includes the pulse being shown.
  always_comb begin
    wraps_next = wraps_reg;
    if (tc_next && (wraps_reg != 8'hFF)) begin
      wraps_next = wraps_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wraps_reg <= '0;
    end else begin
      wraps_reg <= wraps_next;
    end
  end

  assign wraps = wraps_reg;
`endif

endmodule

// File: tb/tb_mod.sv
// Directed, table-driven bench for mod at the default MODULUS of 42.
// Wrap-counter checks are compiled in when MOD_WRAPS_EN is defined.
module tb_mod;

  localparam int MODULUS = 42;
  localparam int W = $clog2(MODULUS);

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc;
`ifdef MOD_WRAPS_EN
  logic [7:0]   wraps;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mod #(.MODULUS(MODULUS)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .up(up),
    .load(load),
    .load_val(load_val),
`ifdef MOD_WRAPS_EN
    .wraps(wraps),
`endif
    .count(count),
    .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         load;
    logic         en;
    logic         up;
    logic [W-1:0] load_val;
    logic [W-1:0] exp_count;
    logic         exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic r, input logic l, input logic e,
                              input logic u, input int lv, input int ec, input logic et);
    vec_t v;
    v.name = name; v.rst = r; v.load = l; v.en = e; v.up = u;
    v.load_val = W'(lv); v.exp_count = W'(ec); v.exp_tc = et;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic u, input int lv);
    rst = r; load = l; en = e; up = u; load_val = W'(lv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;

    //                 name           rst load en up  lv  count tc
    vecs.push_back(mk("reset",          1, 0, 0, 0,  0,  0, 0));
    vecs.push_back(mk("load5",          0, 1, 0, 0,  5,  5, 0));
    vecs.push_back(mk("hold5",          0, 0, 0, 1,  9,  5, 0));
    vecs.push_back(mk("load40",         0, 1, 0, 0, 40, 40, 0));
    vecs.push_back(mk("up41",           0, 0, 1, 1,  0, 41, 0));
    vecs.push_back(mk("up_wrap0",       0, 0, 1, 1,  0,  0, 1));
    vecs.push_back(mk("up1",            0, 0, 1, 1,  0,  1, 0));
    vecs.push_back(mk("down0",          0, 0, 1, 0,  0,  0, 0));
    vecs.push_back(mk("down_wrap41",    0, 0, 1, 0,  0, 41, 1));
    vecs.push_back(mk("down40",         0, 0, 1, 0,  0, 40, 0));
    vecs.push_back(mk("clamp63_en",     0, 1, 1, 1, 63, 41, 0));
    vecs.push_back(mk("clamp42",        0, 1, 0, 0, 42, 41, 0));
    vecs.push_back(mk("rst_over_load",  1, 1, 1, 1,  5,  0, 0));
    vecs.push_back(mk("first_step",     0, 0, 1, 1,  0,  1, 0));
    vecs.push_back(mk("load41",         0, 1, 0, 0, 41, 41, 0));
    vecs.push_back(mk("rst_at_wrap",    1, 0, 1, 1,  0,  0, 0));
    vecs.push_back(mk("no_tc_after_rst",0, 0, 0, 1,  0,  0, 0));
    vecs.push_back(mk("load41b",        0, 1, 0, 0, 41, 41, 0));
    vecs.push_back(mk("load0_no_tc",    0, 1, 1, 1,  0,  0, 0));
    vecs.push_back(mk("dir_down_wrap",  0, 0, 1, 0,  0, 41, 1));
    vecs.push_back(mk("dir_up_wrap",    0, 0, 1, 1,  0,  0, 1));
    vecs.push_back(mk("hold_tc_drop",   0, 0, 0, 1,  0,  0, 0));
    vecs.push_back(mk("load_mid",       0, 1, 0, 1, 20, 20, 0));
    vecs.push_back(mk("down19",         0, 0, 1, 0,  0, 19, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, int'(vecs[i].load_val));
      check({vecs[i].name, ".count"}, int'(count), int'(vecs[i].exp_count));
      check({vecs[i].name, ".tc"}, int'(tc), int'(vecs[i].exp_tc));
      $display("[TB] vec %0d %s: count=%0d tc=%0d", i, vecs[i].name, count, tc);
    end

    // Hold for 10 cycles at 17, toggling the direction input.
    step(0, 1, 0, 0, 17);
    check("hold.load17", int'(count), 17);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, k[0], 33);
      check($sformatf("hold%0d.count", k), int'(count), 17);
      check($sformatf("hold%0d.tc", k), int'(tc), 0);
    end
    $display("[TB] hold sequence done: count=%0d", count);

    // Full up lap from 0: tc must pulse exactly on the 42nd step.
    step(1, 0, 0, 1, 0);
    for (int k = 1; k <= MODULUS; k++) begin
      step(0, 0, 1, 1, 0);
      check($sformatf("lap%0d.count", k), int'(count), k % MODULUS);
      check($sformatf("lap%0d.tc", k), int'(tc), (k == MODULUS) ? 1 : 0);
    end
    $display("[TB] up lap done: count=%0d tc=%0d", count, tc);

`ifdef MOD_WRAPS_EN
    step(1, 0, 0, 1, 0);
    check("wraps.reset", int'(wraps), 0);
    for (int k = 0; k < 600; k++) step(0, 0, 1, 1, 0);
    check("wraps.600", int'(wraps), 600 / MODULUS);
    for (int k = 0; k < 10400; k++) step(0, 0, 1, 1, 0);
    check("wraps.sat", int'(wraps), 255);
    step(0, 0, 0, 1, 0);
    check("wraps.hold", int'(wraps), 255);
    step(1, 0, 1, 1, 0);
    check("wraps.rst", int'(wraps), 0);
    $display("[TB] wraps sequence done: wraps=%0d", wraps);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
